// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              clear;
    logic              write_en;
    logic [DATA_W-1:0] data_in;
    logic              read_en;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output clear, write_en, data_in, read_en,
        input  data_out, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clear, write_en, data_in, read_en,
        output data_out, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered or show-ahead read,
// threshold flags, occupancy count, sticky error flags and synchronous flush.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 2,
    parameter int AFULL_TH  = 3,
    parameter int AEMPTY_TH = 1,
    parameter int FWFT      = 0
) (
    input logic              clock,
    input logic              reset_n,
    sync_fifo_param_if.slave bus
);
    localparam int              DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0] AFULL_LVL  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_LVL = (ADDR_W+1)'(AEMPTY_TH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;
    logic              empty, full, rd_ok, wr_ok;

    // Flags come only from registered pointers, never from the requests.
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    assign rd_ok = bus.read_en & ~empty & ~bus.clear;
    assign wr_ok = bus.write_en & (~full | rd_ok) & ~bus.clear;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
            if (bus.write_en && !wr_ok) overflow_d  = 1'b1;
            if (bus.read_en  && !rd_ok) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (wr_ok) mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.data_in;
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [DATA_W-1:0] data_out_q, data_out_d;
            logic              data_valid_q, data_valid_d;

            always_comb begin
                data_out_d   = data_out_q;
                data_valid_d = 1'b0;
                if (bus.clear) begin
                    data_out_d = '0;
                end else if (rd_ok) begin
                    data_out_d   = mem_q[rd_ptr_q[ADDR_W-1:0]];
                    data_valid_d = 1'b1;
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    data_out_q   <= '0;
                    data_valid_q <= 1'b0;
                end else begin
                    data_out_q   <= data_out_d;
                    data_valid_q <= data_valid_d;
                end
            end

            assign bus.data_out   = data_out_q;
            assign bus.data_valid = data_valid_q;
        end else begin : g_show_ahead
            // Forced to zero while empty so unwritten storage never leaks out.
            assign bus.data_out   = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
            assign bus.data_valid = ~empty;
        end
    endgenerate

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count >= AFULL_LVL);
    assign bus.almost_empty = (count <= AEMPTY_LVL);
    assign bus.count        = count;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: registered-read and show-ahead instances share
// stimulus and are compared against a queue model and a read scoreboard.
module tb_sync_fifo_param;
    localparam int DW = 8, AW = 2, DEPTH = 4, AF = 3, AE = 1;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
    sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

    sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0))
        u_reg (.clock(clock), .reset_n(reset_n), .bus(if0));
    sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1))
        u_fwft (.clock(clock), .reset_n(reset_n), .bus(if1));

    // Reference state
    logic [7:0] q[$];
    logic [7:0] sb0[$];
    logic [7:0] exp_do0;
    logic       ovf, udf;
    int         n_chk, n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [7:0] din, input logic re, input logic clr);
        if0.write_en = we; if0.data_in = din; if0.read_en = re; if0.clear = clr;
        if1.write_en = we; if1.data_in = din; if1.read_en = re; if1.clear = clr;
    endtask

    task automatic model_reset();
        q.delete(); sb0.delete();
        exp_do0 = 8'h00; ovf = 1'b0; udf = 1'b0;
    endtask

    // One clock: inputs applied now, model advanced at the edge.
    task automatic cyc(input logic we, input logic [7:0] din, input logic re, input logic clr);
        logic       rd_ok, wr_ok;
        logic [7:0] w;
        drive(we, din, re, clr);
        @(posedge clock);
        if (clr) begin
            q.delete(); ovf = 1'b0; udf = 1'b0; exp_do0 = 8'h00;
        end else begin
            rd_ok = re && (q.size() != 0);
            wr_ok = we && ((q.size() < DEPTH) || rd_ok);
            if (rd_ok) begin
                w = q.pop_front();
                sb0.push_back(w);
                exp_do0 = w;
            end
            if (wr_ok) q.push_back(din);
            if (we && !wr_ok) ovf = 1'b1;
            if (re && !rd_ok) udf = 1'b1;
        end
        #1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        model_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    // Monitor: status of both instances against the model, read data against scoreboard.
    always @(negedge clock) begin
        int sz;
        logic [7:0] e;
        sz = q.size();
        chk("count0", 32'(if0.count), 32'(sz));
        chk("count1", 32'(if1.count), 32'(sz));
        chk("empty0", 32'(if0.empty), 32'(sz == 0));
        chk("empty1", 32'(if1.empty), 32'(sz == 0));
        chk("full0",  32'(if0.full),  32'(sz == DEPTH));
        chk("full1",  32'(if1.full),  32'(sz == DEPTH));
        chk("afull0", 32'(if0.almost_full),  32'(sz >= AF));
        chk("afull1", 32'(if1.almost_full),  32'(sz >= AF));
        chk("aempty0", 32'(if0.almost_empty), 32'(sz <= AE));
        chk("aempty1", 32'(if1.almost_empty), 32'(sz <= AE));
        chk("ovf0", 32'(if0.overflow),  32'(ovf));
        chk("ovf1", 32'(if1.overflow),  32'(ovf));
        chk("udf0", 32'(if0.underflow), 32'(udf));
        chk("udf1", 32'(if1.underflow), 32'(udf));
        chk("dvalid0", 32'(if0.data_valid), 32'(sb0.size() != 0));
        if (if0.data_valid && sb0.size() != 0) begin
            e = sb0.pop_front();
            chk("rdata0", 32'(if0.data_out), 32'(e));
        end
        chk("dout0_hold", 32'(if0.data_out), 32'(exp_do0));
        chk("dvalid1", 32'(if1.data_valid), 32'(sz != 0));
        chk("dout1", 32'(if1.data_out), (sz != 0) ? 32'(q[0]) : 32'h0);
    end

    initial begin
        n_chk = 0; n_fail = 0;
        model_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #22 reset_n = 1'b1;
        @(posedge clock); #1;

        // Reset mid-operation, then a read on the empty FIFO
        cyc(1, 8'h31, 0, 0);
        cyc(1, 8'h32, 0, 0);
        pulse_reset();
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 0);
        pulse_reset();

        // Fill past full, then drain
        for (int i = 1; i <= 5; i++) cyc(1, 8'(i), 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 0);
        pulse_reset();

        // Read+write while full, then while empty
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'h41 + i), 0, 0);
        cyc(1, 8'h4F, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0);
        cyc(1, 8'h55, 1, 0);
        cyc(0, 8'h00, 1, 0);
        pulse_reset();

        // Interleaved pairs across several pointer wraps
        for (int i = 0; i < 10; i++) begin
            cyc(1, 8'(8'h10 + i), 0, 0);
            cyc(0, 8'h00, 1, 0);
        end

        // Single word for show-ahead visibility and pop
        cyc(1, 8'hA5, 0, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 0);

        // Flush while full with overflow set and a concurrent write
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h60 + i), 0, 0);
        cyc(1, 8'h77, 0, 1);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 1);

        // Random traffic with phases biased toward filling and draining
        for (int i = 0; i < 600; i++) begin
            logic we, re, clr;
            int   bias;
            bias = ((i / 50) % 2 == 0) ? 75 : 25;
            we  = ($urandom_range(0, 99) < bias);
            re  = ($urandom_range(0, 99) < (100 - bias));
            clr = ($urandom_range(0, 59) == 0);
            if (i % 150 == 149) pulse_reset();
            else cyc(we, 8'($urandom), re, clr);
        end
        for (int i = 0; i < 6; i++) cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 0);
        @(negedge clock); #1;
        chk("sb_drained", 32'(sb0.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO. Successor to the fixed 4x8 FIFO used in the RFID baseband data path.
- Generalised in data width and depth. Adds a show-ahead (first-word-fall-through) mode, programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a synchronous flush.
- Fully synchronous to clock: no derived strobes and no internal clock edges.

Parameters:
- DATA_W, 8: data word width in bits.
- ADDR_W, 2: address width; DEPTH = 2^ADDR_W words.
- AFULL_TH, 3: almost_full asserts when count >= AFULL_TH (range 1..DEPTH).
- AEMPTY_TH, 1: almost_empty asserts when count <= AEMPTY_TH (range 0..DEPTH-1).
- FWFT, 0: 0 = registered read (1-cycle latency); 1 = show-ahead.

Ports:
- clock, in, 1: clock; all state updates on the rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- clear, in, 1: synchronous flush; empties the FIFO and clears the error flags.
- write_en, in, 1: write request.
- data_in, in, DATA_W: write data, sampled on the clock edge where write_en=1.
- read_en, in, 1: read/pop request.
- data_out, out, DATA_W: read data.
- data_valid, out, 1: data_out qualifier.
- full, out, 1: count == DEPTH.
- empty, out, 1: count == 0.
- almost_full, out, 1: count >= AFULL_TH.
- almost_empty, out, 1: count <= AEMPTY_TH.
- count, out, ADDR_W+1: current occupancy, 0..DEPTH.
- overflow, out, 1: sticky; a write was rejected.
- underflow, out, 1: sticky; a read was rejected.

Behaviour:
- Interface (already decided): reset reset_n, asynchronous, active-low; clock clock.

Reset and flush:
- While reset_n=0: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, data_valid=0, data_out=0.
- Memory contents are not reset.
- Reset release is synchronous to clock.
- clear=1: identical effect on the next edge; overrides write_en/read_en in the same cycle.

Pointers:
- Binary pointers, ADDR_W+1 bits each; the MSB is the wrap bit.
- empty when the pointers are fully equal.
- full when the MSBs differ and the low ADDR_W bits are equal.
- count = wr_ptr - rd_ptr, computed modulo 2^(ADDR_W+1).
- All flags are registered or derived from registered pointers: no combinational path from write_en/read_en to any flag.

Accept rules (evaluated each edge):
- rd_ok = read_en & !empty.
- wr_ok = write_en & (!full | rd_ok). A write to a full FIFO is accepted if a read is accepted in the same cycle.
- A write to an empty FIFO with read_en=1 in the same cycle: the write is accepted, the read is rejected and counts as underflow.
- wr_ok: mem[wr_ptr] <= data_in; wr_ptr increments.
- rd_ok: rd_ptr increments.
- count changes by +1, -1 or 0 (both or neither accepted). Flags update on the same edge.
- write_en & !wr_ok sets overflow. read_en & !rd_ok sets underflow. Both hold until reset or clear.
- Pointer wrap: the low bits roll over from DEPTH-1 to 0 and the MSB toggles. No other special case.

Read mode FWFT=0:
- On an edge with rd_ok: data_out <= mem[rd_ptr], data_valid <= 1 for exactly one cycle.
- Otherwise data_valid <= 0 and data_out holds its last value.
- Latency: the word is on data_out in the cycle after read_en.

Read mode FWFT=1:
- data_out = mem[rd_ptr] combinationally from registered state; data_valid = !empty.
- read_en pops the word currently displayed.
- A word written at edge N is visible on data_out after edge N, i.e. in cycle N+1.

Ordering:
- Strict FIFO order. No word is lost or duplicated across any wrap.

Test Plan:
(All scenarios use DATA_W=8, ADDR_W=2, AFULL_TH=3, AEMPTY_TH=1.)
1. Reset mid-operation: reset pulse after 2 writes -> count=0, empty=1, flags=0; a subsequent read gives underflow=1 and data_valid stays 0.
2. FWFT=0, fill and drain: write 0x01..0x04 -> almost_full rises at count=3, full=1 at count=4. A 5th write (0x05) sets overflow=1 and count stays 4. Four reads -> data_out 0x01,0x02,0x03,0x04, each one cycle after its read_en with data_valid pulses. Then empty=1, almost_empty=1.
3. Simultaneous read+write while full -> count stays 4, no overflow, and the new word appears 4 reads later. Simultaneous read+write while empty -> write accepted, count=1, underflow=1.
4. Wrap-around: 10 interleaved write/read pairs, data 0x10..0x19 -> output sequence matches exactly, count never exceeds 1, pointers wrap at least twice.
5. FWFT=1: write 0xA5 at edge N -> data_out=0xA5 and data_valid=1 in cycle N+1 without read_en. read_en for one cycle -> empty=1 and data_valid=0 after that edge.
6. clear with full=1, overflow=1, plus write_en=1 in the same cycle -> count=0, empty=1, overflow=0, and the concurrent write is discarded.
